// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: DEPTH-entry valid/ready elastic buffer used as a pipeline
// stage register. It provides strict FIFO order, backpressure, a synchronous
// squash (flush) and an occupancy count.
//
// Optional feature macro: PIPE_REG_ELASTIC_BYPASS_EN
//   When defined, a word offered to an empty buffer is presented on the
//   output combinationally. If it is taken in the same cycle, it is never
//   stored.
//
// Ports:
//   clk        clock, all state on posedge
//   rst        synchronous reset, active-low
//   flush      synchronous squash of all held entries
//   in_valid   upstream payload valid
//   in_ready   buffer can accept a push this cycle
//   in_data    upstream payload [WIDTH]
//   out_valid  head entry valid
//   out_ready  downstream accepts head this cycle
//   out_data   head payload [WIDTH]
//   count      entries held, 0..DEPTH
module pipe_reg_elastic #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             bypass;

    // Pointer increment with wrap at DEPTH-1 (stays 0 when DEPTH==1).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Handshake and head-of-queue view.
    always_comb begin
        in_ready  = (count != FULL) && !flush;
        out_valid = (count != '0) && !flush;
        out_data  = mem[rd_ptr];
        bypass    = 1'b0;
`ifdef PIPE_REG_ELASTIC_BYPASS_EN
        // The empty-buffer pass-through is held off during reset, so reset
        // always shows an idle output.
        if ((count == '0) && rst) begin
            out_valid = in_valid && !flush;
            out_data  = in_data;
        end
`endif
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
`ifdef PIPE_REG_ELASTIC_BYPASS_EN
        bypass = (count == '0) && push && pop;
`endif
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Storage is left as is; out_valid masks the stale head.
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (!bypass) begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic with a queue scoreboard.
// Instance 0 uses DEPTH=2 and instance 1 uses DEPTH=3.
module tb_pipe_reg_elastic;

`ifdef PIPE_REG_ELASTIC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        fl   [2];
    logic        iv   [2];
    logic        ird  [2];
    logic [15:0] din  [2];
    logic        ov   [2];
    logic        ordy [2];
    logic [15:0] dout [2];
    logic [1:0]  cnt  [2];

    int          checks;
    int          errors;
    int          mcnt [2];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    pipe_reg_elastic #(.WIDTH(16), .DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(ird[0]), .in_data(din[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(dout[0]),
        .count(cnt[0])
    );

    pipe_reg_elastic #(.WIDTH(16), .DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(ird[1]), .in_data(din[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(dout[1]),
        .count(cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check instance s against the model, then advance one clock.
    task automatic cycle(input int s);
        logic        er;
        logic        ev;
        logic        pu;
        logic        po;
        logic [15:0] ed;
        int          d;
        d = (s == 0) ? 2 : 3;
        #1;
        er = (mcnt[s] != d) && !fl[s];
        ev = (mcnt[s] != 0) && !fl[s];
        if (BYP && mcnt[s] == 0) ev = iv[s] && !fl[s];
        chk("count", 32'(cnt[s]), 32'(mcnt[s]));
        chk("in_ready", 32'(ird[s]), 32'(er));
        chk("out_valid", 32'(ov[s]), 32'(ev));
        if (ev) begin
            if (BYP && mcnt[s] == 0) ed = din[s];
            else ed = (s == 0) ? q0[0] : q1[0];
            chk("out_data", 32'(dout[s]), 32'(ed));
        end
        pu = iv[s] && er;
        po = ev && ordy[s];
        if (fl[s]) begin
            mcnt[s] = 0;
            if (s == 0) q0.delete(); else q1.delete();
        end else if (!(BYP && mcnt[s] == 0 && pu && po)) begin
            if (po) begin
                if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            if (pu) begin
                if (s == 0) q0.push_back(din[s]); else q1.push_back(din[s]);
            end
            mcnt[s] = mcnt[s] + int'(pu) - int'(po);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int s);
        iv[s]   = 1'b0;
        ordy[s] = 1'b1;
        for (int k = 0; k < 8 && mcnt[s] != 0; k++) cycle(s);
        chk("drain_empty", 32'(mcnt[s]), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        for (int s = 0; s < 2; s++) begin
            fl[s] = 1'b0; iv[s] = 1'b1; din[s] = 16'h5555; ordy[s] = 1'b0; mcnt[s] = 0;
        end

        // Reset held two cycles with in_valid high.
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                chk("rst_out_valid", 32'(ov[s]), 32'd0);
                chk("rst_out_data", 32'(dout[s]), 32'd0);
                chk("rst_in_ready", 32'(ird[s]), 32'd1);
                chk("rst_count", 32'(cnt[s]), 32'd0);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int s = 0; s < 2; s++) iv[s] = 1'b0;

        // Fill a DEPTH=2 buffer, then release while FFFF is waiting.
        ordy[0] = 1'b0; iv[0] = 1'b1;
        din[0] = 16'hA5A5; cycle(0);
        din[0] = 16'h1234; cycle(0);
        din[0] = 16'hFFFF; cycle(0);
        chk("fill_full_count", 32'(cnt[0]), BYP ? 32'd2 : 32'd2);
        ordy[0] = 1'b1;
        cycle(0);
        cycle(0);
        iv[0] = 1'b0;
        drain(0);

        // Stream 1..20 with both sides always ready.
        iv[0] = 1'b1; ordy[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            din[0] = 16'(k);
            cycle(0);
        end
        iv[0] = 1'b0;
        cycle(0);
        drain(0);

        // DEPTH=3 wrap with random backpressure.
        iv[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            din[1]  = 16'($urandom);
            ordy[1] = 1'($urandom_range(0, 1));
            cycle(1);
        end
        drain(1);
        chk("wrap_queue_empty", 32'(q1.size()), 32'd0);

        // Flush at count 2, then a fresh push.
        ordy[0] = 1'b0; iv[0] = 1'b1;
        din[0] = 16'h0101; cycle(0);
        din[0] = 16'h0202; cycle(0);
        fl[0] = 1'b1; din[0] = 16'h0303;
        cycle(0);
        fl[0] = 1'b0; iv[0] = 1'b0;
        cycle(0);
        chk("flush_count", 32'(cnt[0]), 32'd0);
        iv[0] = 1'b1; din[0] = 16'h0042; ordy[0] = 1'b1;
        cycle(0);
        iv[0] = 1'b0;
        #1;
        if (!BYP) chk("flush_next_data", 32'(dout[0]), 32'h0042);
        cycle(0);
        drain(0);

        // Empty buffer offered C3, first taken at once, then held.
        iv[0] = 1'b1; din[0] = 16'h00C3; ordy[0] = 1'b1;
`ifdef PIPE_REG_ELASTIC_BYPASS_EN
        #1;
        chk("byp_out_valid", 32'(ov[0]), 32'd1);
        chk("byp_out_data", 32'(dout[0]), 32'h00C3);
`endif
        cycle(0);
        iv[0] = 1'b0;
        cycle(0);
        iv[0] = 1'b1; ordy[0] = 1'b0;
        cycle(0);
        iv[0] = 1'b0;
        #1;
        chk("hold_count", 32'(cnt[0]), 32'd1);
        cycle(0);
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
